// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: funct3 codes and FSM state encoding shared by the load/store unit
package dmem_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: core request/response and data-memory signals of the load/store unit
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_dat;
  logic [31:0] mem_read_dat;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_dat,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_address, mem_write_dat
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_dat,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_address, mem_write_dat
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// lsu_lane: byte/half lane extraction with extension for loads, lane merge for sub-word stores
module lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  // funct3[2] selects zero extension; funct3[0] picks half over byte for the store merge
  always_comb begin
    w_byte  = 8'(i_word >> {i_off, 3'b000});
    w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_funct3[1:0] == F3_B[1:0] ? {{24{w_byte[7] & ~i_funct3[2]}}, w_byte} :
              i_funct3[1:0] == F3_H[1:0] ? {{16{w_half[15] & ~i_funct3[2]}}, w_half} : i_word;
    w_mask  = i_funct3[0] ? 32'h0000_ffff << {i_off[1], 4'b0000} : 32'h0000_00ff << {i_off, 3'b000};
    w_ins   = i_funct3[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
    o_merge = (i_word & ~w_mask) | (w_ins & w_mask);
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32I load/store unit in front of a word-wide data memory
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter bit MISALIGN_TRAP = 1'b1,
  parameter bit SUBWORD_EN    = 1'b1
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave bus
);
  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_valid;
  logic        r_err;
  logic        w_ill;
  logic        w_mis;
  logic        w_sub;
  logic        w_err;
  logic        w_sw;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  lsu_lane u_lane (
    .i_funct3(r_funct3),
    .i_off   (r_addr[1:0]),
    .i_word  (bus.mem_read_dat),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_merge (w_merge)
  );
  // Decode the latched request; only meaningful while in EXEC
  always_comb begin
    w_ill = r_we ? !(r_funct3 inside {F3_B, F3_H, F3_W}) :
                   !(r_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_mis = (r_funct3[1:0] == F3_H[1:0] && r_addr[0]) ||
            (r_funct3[1:0] == F3_W[1:0] && r_addr[1:0] != 2'b00);
    w_sub = r_funct3[1:0] != F3_W[1:0];
    w_err = w_ill || (MISALIGN_TRAP && w_mis) || (!SUBWORD_EN && w_sub);
    w_sw  = r_state == EXEC && r_we && !w_err && !w_sub;
  end
  assign bus.req_ready     = r_state == IDLE;
  assign bus.resp_valid    = r_valid;
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_err      = r_err;
  assign bus.mem_address   = {2'b00, r_addr[31:2]};
  assign bus.mem_write_en  = !reset && (w_sw || r_state == WRITE);
  assign bus.mem_write_dat = w_sw ? r_wdata : r_state == WRITE ? r_merge : 32'h0;
  // Request capture, one-cycle execute/merge, optional write-back cycle, registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_addr   <= bus.req_addr;
          r_wdata  <= bus.req_wdata;
          r_funct3 <= bus.req_funct3;
          r_we     <= bus.req_we;
          r_state  <= EXEC;
        end
        EXEC: if (w_err || !r_we || !w_sub) begin
          r_valid <= 1'b1;
          r_err   <= w_err;
          r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
          r_state <= IDLE;
        end else begin
          r_merge <= w_merge;
          r_state <= WRITE;
        end
        WRITE: begin
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random load/store traffic against a byte-array reference model
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dmem_lsu_if bus ();
  dmem_lsu dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [256];
  logic [31:0] init_w [256];
  logic [7:0]  mdl_b [1024];
  int n_cmp = 0;
  int n_err = 0;
  assign bus.mem_read_dat = mem[bus.mem_address[7:0]];
  // Data memory: preloaded while reset is held, word writes otherwise
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_w[i];
    end else if (bus.mem_write_en) mem[bus.mem_address[7:0]] <= bus.mem_write_dat;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mdl_word(input logic [7:0] w);
    int b;
    b = int'(w) * 4;
    return {mdl_b[b+3], mdl_b[b+2], mdl_b[b+1], mdl_b[b]};
  endfunction
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
    int sz, a, lat, wc, e_lat, e_wc;
    logic e_err;
    logic [31:0] e_rd;
    longint v;
    bit ill;
    sz = 1 << f3[1:0];
    a = int'(addr[9:0]);
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    e_err = ill || (a % sz != 0);
    e_rd = 32'h0;
    e_lat = 2;
    e_wc = 0;
    if (!e_err && we) begin
      for (int i = 0; i < sz; i++) mdl_b[a+i] = wdata[8*i+:8];
      e_wc = 1;
      if (sz < 4) e_lat = 3;
    end else if (!e_err) begin
      v = 0;
      for (int i = 0; i < sz; i++) v |= longint'(mdl_b[a+i]) << (8 * i);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v -= longint'(1) << (8 * sz);
      e_rd = v[31:0];
    end
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    wc = 0;
    while (!bus.resp_valid && lat < 10) begin
      wc += int'(bus.mem_write_en);
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    chk("latency", lat, e_lat);
    chk("write_cycles", wc, e_wc);
    chk("resp_err", 32'(er), 32'(e_err));
    chk("resp_rdata", rd, e_rd);
    chk("mem_word", mem[addr[9:2]], mdl_word(addr[9:2]));
  endtask
  initial begin
    logic [31:0] rd, w, a, old;
    logic er, we;
    logic [2:0] f3;
    int pulses;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      init_w[i] = w;
      for (int j = 0; j < 4; j++) mdl_b[4*i+j] = w[8*j+:8];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_write_en", 32'(bus.mem_write_en), 32'd0);
    chk("rst_address", bus.mem_address, 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b1, 3'b010, 32'h10, 32'hdeadbeef, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw_deadbeef", rd, 32'hdeadbeef);
    do_req(1'b1, 3'b000, 32'h11, 32'h0000005a, rd, er);
    chk("sb_merge", mem[4], 32'hdead5aef);
    do_req(1'b1, 3'b010, 32'h10, 32'h80ff0000, rd, er);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
    chk("lb_sign", rd, 32'hffffff80);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er);
    chk("lbu_zero", rd, 32'h00000080);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, er);
    chk("lhu_zero", rd, 32'h000080ff);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, er);
    chk("lw_misaligned_err", 32'(er), 32'd1);
    do_req(1'b1, 3'b001, 32'h11, 32'h1234, rd, er);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    chk("sh_misaligned_mem", mem[4], 32'h80ff0000);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
    chk("illegal_load_err", 32'(er), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) begin
        pulses++;
        chk("b2b_rdata", bus.resp_rdata, mdl_word(8'd4));
        chk("b2b_ready", 32'(bus.req_ready), 32'd1);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_pulses", pulses, 4);
    @(posedge clk);
    old = mdl_word(8'd8);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h20;
    bus.req_wdata = 32'h000000a5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_write_en_before", 32'(bus.mem_write_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_write_en", 32'(bus.mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_resp_valid_after", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 256; i++) begin
      w = init_w[i];
      for (int j = 0; j < 4; j++) mdl_b[4*i+j] = w[8*j+:8];
    end
    chk("rstw_mem", mem[8], mdl_word(8'd8));
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
           (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      do_req(we, f3, a, $urandom, rd, er);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
